// File: rtl/knn_controller_if.sv
// Handshake bundle between the KNN inference sequencer and its host, sample memory and datapath.
// The master side is the sequencer; the slave side is everything it talks to.
interface knn_controller_if #(
  parameter int L      = 6,
  parameter int TYPE_W = 3
);
  logic              start;
  logic [L:0]        n_samples;
  logic              busy;
  logic              mem_req;
  logic [L-1:0]      mem_addr;
  logic              mem_ack;
  logic              calc_ready;
  logic              calc_data_request;
  logic              calc_done;
  logic              array_clear;
  logic              slot_we;
  logic [L-1:0]      slot_idx;
  logic              sort_start;
  logic              sort_valid;
  logic              infer_done;
  logic [TYPE_W-1:0] infer_type;
  logic [TYPE_W-1:0] result_type;
  logic              result_valid;
  logic              result_ready;
  logic              error;

  modport master (
    input  start, n_samples, mem_ack, calc_data_request, calc_done,
           sort_valid, infer_done, infer_type, result_ready,
    output busy, mem_req, mem_addr, calc_ready, array_clear, slot_we,
           slot_idx, sort_start, result_type, result_valid, error
  );

  modport slave (
    output start, n_samples, mem_ack, calc_data_request, calc_done,
           sort_valid, infer_done, infer_type, result_ready,
    input  busy, mem_req, mem_addr, calc_ready, array_clear, slot_we,
           slot_idx, sort_start, result_type, result_valid, error
  );
endinterface

// File: rtl/knn_controller.sv
// Sequencer for one KNN inference: clear, fetch/compute every sample, sort, vote, and hand the
// voted type to the host. Every wait on an external event is bounded by a shared timeout counter.
module knn_controller #(
  parameter int L       = 6,
  parameter int TYPE_W  = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  knn_controller_if.master bus
);
  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [L-1:0]  IDX_ONE    = {{(L-1){1'b0}}, 1'b1};
  localparam logic [L:0]    N_ONE      = {{L{1'b0}}, 1'b1};
  localparam logic [L:0]    N_MAX      = {1'b1, {L{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    WAIT_MEM,
    CALC,
    SORT,
    VOTE,
    RESULT
  } state_t;

  state_t            state_reg;
  logic [L-1:0]      idx_reg;
  logic [TW-1:0]     timer_reg;
  logic [L:0]        n_reg;
  logic              busy_reg;
  logic              mem_req_reg;
  logic [L-1:0]      mem_addr_reg;
  logic              calc_ready_reg;
  logic              array_clear_reg;
  logic              sort_start_reg;
  logic [TYPE_W-1:0] result_type_reg;
  logic              result_valid_reg;
  logic              error_reg;

  logic timer_expired;
  logic last_sample;
  logic start_legal;

  assign timer_expired = (timer_reg == TIMER_LAST);
  // Compare one wider than idx so a full 2^L run never needs idx to wrap.
  assign last_sample   = (({1'b0, idx_reg} + N_ONE) == n_reg);
  assign start_legal   = (bus.n_samples != '0) && (bus.n_samples <= N_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      idx_reg          <= '0;
      timer_reg        <= '0;
      n_reg            <= '0;
      busy_reg         <= 1'b0;
      mem_req_reg      <= 1'b0;
      mem_addr_reg     <= '0;
      calc_ready_reg   <= 1'b0;
      array_clear_reg  <= 1'b0;
      sort_start_reg   <= 1'b0;
      result_type_reg  <= '0;
      result_valid_reg <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      mem_req_reg     <= 1'b0;
      calc_ready_reg  <= 1'b0;
      array_clear_reg <= 1'b0;
      sort_start_reg  <= 1'b0;
      error_reg       <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            if (start_legal) begin
              n_reg           <= bus.n_samples;
              array_clear_reg <= 1'b1;
              busy_reg        <= 1'b1;
              state_reg       <= CLEAR;
            end else begin
              error_reg <= 1'b1;
            end
          end
        end

        CLEAR: begin
          idx_reg   <= '0;
          state_reg <= FETCH;
        end

        FETCH: begin
          if (bus.calc_data_request) begin
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= idx_reg;
            timer_reg    <= '0;
            state_reg    <= WAIT_MEM;
          end
        end

        // In each timed state the awaited event is tested first, so it wins on the expiry cycle.
        WAIT_MEM: begin
          if (bus.mem_ack) begin
            calc_ready_reg <= 1'b1;
            timer_reg      <= '0;
            state_reg      <= CALC;
          end else if (timer_expired) begin
            error_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg + TIMER_ONE;
          end
        end

        CALC: begin
          if (bus.calc_done) begin
            timer_reg <= '0;
            if (last_sample) begin
              sort_start_reg <= 1'b1;
              state_reg      <= SORT;
            end else begin
              idx_reg   <= idx_reg + IDX_ONE;
              state_reg <= FETCH;
            end
          end else if (timer_expired) begin
            error_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg + TIMER_ONE;
          end
        end

        SORT: begin
          if (bus.sort_valid) begin
            timer_reg <= '0;
            state_reg <= VOTE;
          end else if (timer_expired) begin
            error_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg + TIMER_ONE;
          end
        end

        VOTE: begin
          if (bus.infer_done) begin
            result_type_reg  <= bus.infer_type;
            result_valid_reg <= 1'b1;
            timer_reg        <= '0;
            state_reg        <= RESULT;
          end else if (timer_expired) begin
            error_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg + TIMER_ONE;
          end
        end

        RESULT: begin
          if (bus.result_ready) begin
            result_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            state_reg        <= IDLE;
          end
        end

        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // The slot write is combinational so the array captures the distance in the calc_done cycle.
  assign bus.slot_we      = bus.calc_done && (state_reg == CALC);
  assign bus.slot_idx     = idx_reg;

  assign bus.busy         = busy_reg;
  assign bus.mem_req      = mem_req_reg;
  assign bus.mem_addr     = mem_addr_reg;
  assign bus.calc_ready   = calc_ready_reg;
  assign bus.array_clear  = array_clear_reg;
  assign bus.sort_start   = sort_start_reg;
  assign bus.result_type  = result_type_reg;
  assign bus.result_valid = result_valid_reg;
  assign bus.error        = error_reg;
endmodule

// File: tb/tb_knn_controller.sv
// Self-checking bench for knn_controller: the bench plays host, memory and datapath, and checks
// each job against the expected job-level outcome (fetch order, slot fill, one sort, voted result).
module tb_knn_controller;
  localparam int L       = 6;
  localparam int TYPE_W  = 3;
  localparam int TIMEOUT = 1023;
  localparam int NMAX    = 1 << L;
  localparam int BUDGET  = 6000;

  logic clk;
  logic rst;

  knn_controller_if #(.L(L), .TYPE_W(TYPE_W)) bus ();

  knn_controller #(.L(L), .TYPE_W(TYPE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations of the most recent job.
  int addr_q[$];
  int slot_q[$];
  int sorts, clears, errs, err_delta, hold_bad, busy1, finished;
  int res_seen, res_type_obs, valid_after;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.start             = 1'b0;
    bus.n_samples         = '0;
    bus.mem_ack           = 1'b0;
    bus.calc_data_request = 1'b0;
    bus.calc_done         = 1'b0;
    bus.sort_valid        = 1'b0;
    bus.infer_done        = 1'b0;
    bus.infer_type        = '0;
    bus.result_ready      = 1'b0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, " busy"},         bus.busy,         0);
    chk({pfx, " mem_req"},      bus.mem_req,      0);
    chk({pfx, " mem_addr"},     bus.mem_addr,     0);
    chk({pfx, " calc_ready"},   bus.calc_ready,   0);
    chk({pfx, " array_clear"},  bus.array_clear,  0);
    chk({pfx, " slot_we"},      bus.slot_we,      0);
    chk({pfx, " slot_idx"},     bus.slot_idx,     0);
    chk({pfx, " sort_start"},   bus.sort_start,   0);
    chk({pfx, " result_type"},  bus.result_type,  0);
    chk({pfx, " result_valid"}, bus.result_valid, 0);
    chk({pfx, " error"},        bus.error,        0);
  endtask

  // Environment for one job. wh: ordinal of the mem_req whose ack is withheld (-1 none);
  // expiry_ack acks that request exactly on the last allowed cycle instead.
  task automatic run_job(input int n, input int ml, input int cl, input int wh,
                         input bit expiry_ack, input bit spur, input int rdy_wait,
                         input int itype, input bit rst_mid);
    int cyc, nreq, req_cyc, pend_ack, pend_done, pend_sv, pend_id, rstate, rcnt;
    bit done, ready_now;
    addr_q.delete();
    slot_q.delete();
    sorts = 0; clears = 0; errs = 0; err_delta = -1; hold_bad = 0; busy1 = 0;
    finished = 0; res_seen = 0; res_type_obs = -1; valid_after = -1;
    cyc = 0; nreq = 0; req_cyc = 0; rstate = 0; rcnt = 0; done = 1'b0;
    pend_ack = -1; pend_done = -1; pend_sv = -1; pend_id = -1;
    while (!done) begin
      @(negedge clk);
      ready_now = 1'b0;
      if (cyc == 1) busy1 = int'(bus.busy);
      if (bus.mem_req) begin
        addr_q.push_back(int'(bus.mem_addr));
        req_cyc = cyc;
        if (nreq == wh) pend_ack = expiry_ack ? cyc + TIMEOUT - 1 : -1;
        else pend_ack = cyc + ((ml > 0) ? ml : int'($urandom_range(1, 4)));
        nreq++;
      end
      if (bus.calc_ready) begin
        if (rst_mid && nreq == 2) begin
          #2 rst = 1'b0;
          #1 chk_all_zero("rst mid-calc");
          drive_idle();
          @(negedge clk);
          rst = 1'b1;
          done = 1'b1;
        end else begin
          pend_done = cyc + ((cl > 0) ? cl : int'($urandom_range(1, 6)));
        end
      end
      if (!done) begin
        if (bus.sort_start) begin
          sorts++;
          pend_sv = cyc + int'($urandom_range(1, 5));
        end
        if (bus.array_clear) clears++;
        if (bus.error) begin
          errs++;
          err_delta = cyc - req_cyc;
        end
        if (rstate == 2) begin
          valid_after = int'(bus.result_valid);
          rstate = 3;
        end
        if (rstate == 0 && bus.result_valid) begin
          res_seen = 1;
          res_type_obs = int'(bus.result_type);
          rstate = 1;
          rcnt = 0;
        end
        if (rstate == 1) begin
          if (bus.result_valid !== 1'b1 || int'(bus.result_type) != res_type_obs) hold_bad++;
          if (rcnt == rdy_wait) begin
            ready_now = 1'b1;
            rstate = 2;
          end else begin
            rcnt++;
          end
        end
        if (cyc >= 2 && !bus.busy) begin
          finished = 1;
          done = 1'b1;
          drive_idle();
        end
      end
      if (!done) begin
        bus.start             = (cyc == 0);
        bus.n_samples         = n[L:0];
        bus.calc_data_request = ($urandom_range(0, 3) != 0);
        bus.mem_ack           = (cyc == pend_ack);
        bus.calc_done         = (cyc == pend_done);
        bus.sort_valid        = (cyc == pend_sv);
        if (bus.sort_valid) pend_id = cyc + int'($urandom_range(1, 4));
        bus.infer_done        = (cyc == pend_id);
        bus.infer_type        = bus.infer_done ? TYPE_W'(itype) : TYPE_W'($urandom);
        bus.result_ready      = ready_now;
        // Stray events aimed at states that must ignore them.
        if (spur && pend_done > cyc) begin
          bus.mem_ack    = bus.mem_ack | ($urandom_range(0, 1) == 1);
          bus.infer_done = bus.infer_done | ($urandom_range(0, 2) == 0);
          bus.start      = bus.start | ($urandom_range(0, 1) == 1);
        end
        if (spur && pend_ack > cyc) begin
          bus.calc_done  = bus.calc_done | ($urandom_range(0, 1) == 1);
          bus.sort_valid = bus.sort_valid | ($urandom_range(0, 2) == 0);
        end
        #1;
        if (bus.slot_we) slot_q.push_back(int'(bus.slot_idx));
        cyc++;
        if (cyc > BUDGET) done = 1'b1;
      end
    end
  endtask

  // A completed job fetches samples 0..n-1 in order, fills slots 0..n-1, sorts once, returns itype.
  task automatic check_job_ok(input int n, input int itype, input string pfx);
    int exp_q[$];
    int addr_err, slot_err;
    for (int i = 0; i < n; i++) exp_q.push_back(i);
    addr_err = 0;
    slot_err = 0;
    for (int i = 0; i < addr_q.size() && i < n; i++) if (addr_q[i] != exp_q[i]) addr_err++;
    for (int i = 0; i < slot_q.size() && i < n; i++) if (slot_q[i] != exp_q[i]) slot_err++;
    chk({pfx, " finished"},      finished,      1);
    chk({pfx, " busy"},          busy1,         1);
    chk({pfx, " clears"},        clears,        1);
    chk({pfx, " mem_req count"}, addr_q.size(), n);
    chk({pfx, " mem_addr seq"},  addr_err,      0);
    chk({pfx, " slot count"},    slot_q.size(), n);
    chk({pfx, " slot_idx seq"},  slot_err,      0);
    chk({pfx, " sort_start"},    sorts,         1);
    chk({pfx, " error"},         errs,          0);
    chk({pfx, " result seen"},   res_seen,      1);
    chk({pfx, " result_type"},   res_type_obs,  itype);
    chk({pfx, " result hold"},   hold_bad,      0);
    chk({pfx, " valid cleared"}, valid_after,   0);
    $display("job %s: n=%0d type=%0d mem_reqs=%0d slots=%0d", pfx, n, res_type_obs,
             addr_q.size(), slot_q.size());
  endtask

  initial begin
    int bad_n[3];
    int quiet, n, t;
    rst = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    bad_n[0] = 0;
    bad_n[1] = NMAX + 1;
    bad_n[2] = int'($urandom_range(NMAX + 2, 2 * NMAX - 1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.n_samples = bad_n[i][L:0];
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("illegal error", bus.error, 1);
      chk("illegal busy", bus.busy, 0);
      quiet = 0;
      repeat (6) begin
        @(negedge clk);
        quiet += int'(bus.busy) + int'(bus.mem_req) + int'(bus.error) + int'(bus.array_clear);
      end
      chk("illegal quiet", quiet, 0);
      $display("illegal start n=%0d: error pulse checked", bad_n[i]);
    end

    run_job(4, 2, 5, -1, 1'b0, 1'b0, 0, 3, 1'b0);
    check_job_ok(4, 3, "n4");
    run_job(NMAX, 0, 0, -1, 1'b0, 1'b0, 10, 5, 1'b0);
    check_job_ok(NMAX, 5, "full");
    chk("full last slot", slot_q[slot_q.size() - 1], NMAX - 1);
    run_job(1, 0, 0, -1, 1'b0, 1'b0, 1, 7, 1'b0);
    check_job_ok(1, 7, "n1");
    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(1, NMAX));
      t = int'($urandom_range(0, 7));
      run_job(n, 0, 0, -1, 1'b0, 1'b1, int'($urandom_range(0, 3)), t, 1'b0);
      check_job_ok(n, t, "spurious");
    end

    run_job(4, 0, 0, 1, 1'b0, 1'b0, 0, 2, 1'b0);
    chk("timeout finished", finished, 1);
    chk("timeout error count", errs, 1);
    chk("timeout latency", err_delta, TIMEOUT);
    chk("timeout mem_reqs", addr_q.size(), 2);
    chk("timeout slots", slot_q.size(), 1);
    chk("timeout no result", res_seen, 0);
    chk("timeout result_valid", bus.result_valid, 0);
    $display("timeout job: error after %0d cycles", err_delta);

    run_job(4, 0, 0, 1, 1'b1, 1'b0, 2, 6, 1'b0);
    check_job_ok(4, 6, "expiry ack");

    run_job(8, 0, 0, -1, 1'b0, 1'b0, 0, 1, 1'b1);
    chk("rst slots before abort", slot_q.size(), 1);
    n = int'($urandom_range(2, NMAX));
    t = int'($urandom_range(0, 7));
    run_job(n, 0, 0, -1, 1'b0, 1'b0, 1, t, 1'b0);
    check_job_ok(n, t, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
